// File: rtl/pred_pkg.sv
// pred_pkg: shared constants, FSM state type and double-classification helper for pred_result_writer
// Optional feature macro: PRED_RESULT_WRITER_CHECKSUM_EN adds the CHK state.
package pred_pkg;
  localparam logic [31:0] HDR_MAGIC = 32'h50524544;
  localparam logic [31:0] TRL_MAGIC = 32'h41434355;
  localparam logic [10:0] EXP_HALF = 11'h3FE;
`ifdef PRED_RESULT_WRITER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR, BODY, CHK, TRL, DONE} state_t;
`else
  typedef enum logic [2:0] {HDR, BODY, TRL, DONE} state_t;
`endif
  // Positive and at least 0.5; +Inf and positive NaN land here too.
  function automatic logic dbl_class(input logic [63:0] d);
    return !d[63] && d[62:52] >= EXP_HALF;
  endfunction
endpackage

// File: rtl/pred_result_writer_if.sv
// pred_result_writer_if: input record handshake and output word stream of pred_result_writer
// Ports: in_valid/in_ready/in_pred/in_actual (records in), out_valid/out_ready/out_data/out_last (words out).
// slave = the writer, master = the upstream source / downstream sink.
interface pred_result_writer_if;
  logic in_valid;
  logic in_ready;
  logic [63:0] in_pred;
  logic [63:0] in_actual;
  logic out_valid;
  logic out_ready;
  logic [63:0] out_data;
  logic out_last;
  modport slave (input in_valid, in_pred, in_actual, out_ready, output in_ready, out_valid, out_data, out_last);
  modport master (output in_valid, in_pred, in_actual, out_ready, input in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy; dout reads 0 while empty
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty.
// Push while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/pred_result_writer.sv
// pred_result_writer: classifies (prediction, actual) double pairs and frames them as header/records/trailer words
// Ports: clk, rst (sync, active-high), io (pred_result_writer_if.slave), correct_cnt (running matches),
// acc_cal (sticky, set once the trailer word is accepted downstream).
// Macro PRED_RESULT_WRITER_CHECKSUM_EN: emit an XOR of header and records just before the trailer.
module pred_result_writer
  import pred_pkg::*;
#(
  parameter int ROWS = 100,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  pred_result_writer_if.slave io,
  output logic [15:0] correct_cnt,
  output logic acc_cal
);
  localparam logic [15:0] R16 = 16'(ROWS);
  state_t state;
  logic [15:0] idx;
  logic full, empty, push, acc, pc, ac, m;
  logic [63:0] hdr, rec, trl, tail, word;
  logic [64:0] head;
  assign pc = dbl_class(io.in_pred);
  assign ac = dbl_class(io.in_actual);
  assign m = pc == ac;
  assign hdr = {HDR_MAGIC, 16'h0000, R16};
  assign rec = {io.in_pred[63:32], idx, 13'b0, m, ac, pc};
  assign trl = {TRL_MAGIC, correct_cnt, R16};
  // full is registered, so a pop in the same cycle never opens room for a push
  assign io.in_ready = state == BODY && !full;
  assign acc = io.in_valid && io.in_ready;
  assign push = state == BODY ? acc : state != DONE && !full;
`ifdef PRED_RESULT_WRITER_CHECKSUM_EN
  logic [63:0] chk;
  assign tail = state == CHK ? chk : trl;
`else
  assign tail = trl;
`endif
  assign word = state == HDR ? hdr : state == BODY ? rec : tail;
  assign io.out_valid = !empty;
  assign io.out_data = head[63:0];
  assign io.out_last = head[64];
  sync_fifo #(.WIDTH(65), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(io.out_ready),
    .din({state == TRL, word}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR;
      idx <= '0;
      correct_cnt <= '0;
      acc_cal <= 1'b0;
`ifdef PRED_RESULT_WRITER_CHECKSUM_EN
      chk <= '0;
`endif
    end else begin
      if (io.out_valid && io.out_ready && io.out_last) acc_cal <= 1'b1;
      unique case (state)
        HDR: if (!full) begin
          state <= BODY;
`ifdef PRED_RESULT_WRITER_CHECKSUM_EN
          chk <= hdr;
`endif
        end
        BODY: if (acc) begin
          idx <= idx + 16'd1;
          correct_cnt <= correct_cnt + 16'(m);
`ifdef PRED_RESULT_WRITER_CHECKSUM_EN
          chk <= chk ^ rec;
          if (idx == R16 - 16'd1) state <= CHK;
`else
          if (idx == R16 - 16'd1) state <= TRL;
`endif
        end
`ifdef PRED_RESULT_WRITER_CHECKSUM_EN
        CHK: if (!full) state <= TRL;
`endif
        TRL: if (!full) state <= DONE;
        default: ;
      endcase
    end
  end
endmodule
